synch: RTL and testbench
========================

SYNCH -- requirements
Module: synch

Interface
REQ-001 The block SHALL have parameter STAGES, default 2, giving the number of flip-flops in the synchronizer chain.
REQ-002 The block SHALL have parameter RESET_VAL, default 1'b0, giving the value loaded into every internal flop on reset.
REQ-003 The block SHALL have port clk  input  1  the single clock; all flops SHALL update on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port in  input  1  an asynchronous level (switch or key), possibly metastable relative to clk.
REQ-006 The block SHALL have port out  output  1  the synchronized version of in (a level, or a pulse per REQ-017).

Function
REQ-007 The block SHALL implement a chain s[0..STAGES-1], with s[0] <= in and s[i] <= s[i-1] on each rising edge of clk when reset is low.
REQ-008 In level mode, out SHALL equal s[STAGES-1] and be driven directly from a flop, with no combinational path from in to out.
REQ-009 Latency SHALL be exactly STAGES rising edges: for STAGES=2, a value of in sampled at edge k SHALL appear on out immediately after edge k+1.
REQ-010 Every change of in, including a one-cycle pulse, SHALL be reproduced on out with no filtering; in held for N cycles SHALL give out high for N cycles.
REQ-011 Back-to-back toggles of in on every edge SHALL appear on out as the same toggle pattern, delayed by STAGES cycles.
REQ-012 STAGES < 2 SHALL be an elaboration-time error; there SHALL be no upper limit other than the tool's limit.

Reset
REQ-013 When reset is high at a rising edge, every s[i] (and prev per REQ-017) SHALL load RESET_VAL, regardless of in.
REQ-014 During reset and on the first cycle after it, out SHALL equal RESET_VAL in level mode and 0 in pulse mode.
REQ-015 If reset is asserted while data is in flight, the in-flight data SHALL be discarded; after reset is released, out SHALL reflect only in values sampled after the release.
REQ-016 Reset SHALL NOT be synchronized internally; its timing is the responsibility of the driving logic.

Configuration
REQ-017 When macro SYNCH_PULSE_EN is defined, the block SHALL add a flop prev <= s[STAGES-1], and out SHALL equal s[STAGES-1] AND NOT prev.
REQ-018 In pulse mode, each rising edge of the synchronized level SHALL produce exactly one one-cycle-high pulse, with the same latency as level mode.
REQ-019 If RESET_VAL=0 and in is high when reset is released, one pulse SHALL be produced after STAGES edges.
REQ-020 When SYNCH_PULSE_EN is undefined, the prev flop SHALL NOT exist and the block SHALL behave per REQ-008.

Structure
REQ-021 Package synch_pkg SHALL hold constant SYNCH_STAGES_MIN = 2 and the default-reset constant SYNCH_RESET_DEFAULT = 1'b0; the module SHALL use both.
REQ-022 Sub-module synch_ff SHALL be a single D flop with synchronous active-high reset and parameter RESET_VAL.
REQ-023 synch SHALL instantiate STAGES copies of synch_ff in a generate loop, plus one more copy for prev in pulse mode.
REQ-024 The chain flops SHALL carry a synthesis attribute marking them as an asynchronous-register chain, so they are kept together and not retimed.

Verification
REQ-025 Test: reset high for 2 edges with in=1 -> out=0 throughout, and for 1 cycle after release.
REQ-026 Test: STAGES=2, in driven 0,1,1,1,0,0,1,0,0,0 on successive edges -> out shows the same sequence delayed 2 cycles, with a 3-cycle high pulse and a 1-cycle high pulse.
REQ-027 Test: in toggling every cycle for 8 cycles -> out toggles every cycle, 2 cycles later.
REQ-028 Test: reset asserted 1 cycle after in rises -> out stays 0; out rises only for in samples taken after the release.
REQ-029 Test: SYNCH_PULSE_EN defined, in high for 3 cycles -> out high for exactly 1 cycle, 2 edges after in is first sampled.
REQ-030 Test: STAGES=3 with a single-cycle in=1 -> out high for exactly 1 cycle, 3 edges later; STAGES=1 -> elaboration fails.

Source files
------------

// File: rtl/synch_pkg.sv
// Shared constants for the synch level/pulse synchronizer.
package synch_pkg;

  localparam int   SYNCH_STAGES_MIN    = 2;
  localparam logic SYNCH_RESET_DEFAULT = 1'b0;

endpackage

// File: rtl/synch_ff.sv
// Single D flop with synchronous active-high reset; one link of the synch chain.
module synch_ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) r_q <= RESET_VAL;
    else       r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/synch.sv
// Multi-flop synchronizer for an asynchronous level; reset is taken as already synchronous.
// Build option: define SYNCH_PULSE_EN to turn the output into a one-cycle rising-edge pulse.
module synch
  import synch_pkg::*;
#(
  parameter int   STAGES    = SYNCH_STAGES_MIN,
  parameter logic RESET_VAL = SYNCH_RESET_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  if (STAGES < SYNCH_STAGES_MIN) begin : g_stages_check
    $error("synch: STAGES must be at least %0d", SYNCH_STAGES_MIN);
  end

  logic [STAGES-1:0] w_s;
  logic [STAGES-1:0] w_d;

  // Stage k samples stage k-1; stage 0 samples the raw asynchronous input.
  assign w_d = {w_s[STAGES-2:0], in};

  for (genvar k = 0; k < STAGES; k++) begin : g_chain
    (* ASYNC_REG = "TRUE" *)
    synch_ff #(
      .RESET_VAL (RESET_VAL)
    ) u_ff (
      .clk   (clk),
      .reset (reset),
      .i_d   (w_d[k]),
      .o_q   (w_s[k])
    );
  end

`ifdef SYNCH_PULSE_EN
  logic w_prev;

  synch_ff #(
    .RESET_VAL (RESET_VAL)
  ) u_prev (
    .clk   (clk),
    .reset (reset),
    .i_d   (w_s[STAGES-1]),
    .o_q   (w_prev)
  );

  // prev resets to the same value as the chain, so no pulse is emitted out of reset.
  assign out = w_s[STAGES-1] & ~w_prev;
`else
  assign out = w_s[STAGES-1];
`endif

endmodule

// File: tb/tb_synch.sv
// Directed bench for synch: three instances (2 stages, 3 stages, 2 stages with reset value 1)
// share one stimulus table; expectations are hand-derived per cycle for level or pulse build.
module tb_synch;

  localparam int N = 34;

  logic clk;
  logic reset;
  logic r_in;
  logic w_out2;
  logic w_out3;
  logic w_out2r1;

  int n_checks = 0;
  int n_errors = 0;

  synch #(.STAGES(2), .RESET_VAL(1'b0)) u_s2 (
    .clk (clk), .reset (reset), .in (r_in), .out (w_out2)
  );

  synch #(.STAGES(3), .RESET_VAL(1'b0)) u_s3 (
    .clk (clk), .reset (reset), .in (r_in), .out (w_out3)
  );

  synch #(.STAGES(2), .RESET_VAL(1'b1)) u_s2r1 (
    .clk (clk), .reset (reset), .in (r_in), .out (w_out2r1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row j is applied before rising edge j; expected values are out just after edge j.
  bit v_rst [N] = '{1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,
                    0,0,0,0,0,0,0,1,0,0, 0,0,0,0};
  bit v_in  [N] = '{1,1,1,0,0,0,0,1,1,1, 0,0,1,0,0,0,1,0,1,0,
                    1,0,1,0,0,0,1,1,0,0, 1,0,0,0};
`ifdef SYNCH_PULSE_EN
  bit e_s2  [N] = '{0,0,0,1,0,0,0,0,1,0, 0,0,0,1,0,0,0,1,0,1,
                    0,1,0,1,0,0,0,0,0,0, 0,1,0,0};
  bit e_s3  [N] = '{0,0,0,0,1,0,0,0,0,1, 0,0,0,0,1,0,0,0,1,0,
                    1,0,1,0,1,0,0,0,0,0, 0,0,1,0};
  bit e_s2r1[N] = '{0,0,0,0,0,0,0,0,1,0, 0,0,0,1,0,0,0,1,0,1,
                    0,1,0,1,0,0,0,0,0,0, 0,1,0,0};
`else
  bit e_s2  [N] = '{0,0,0,1,0,0,0,0,1,1, 1,0,0,1,0,0,0,1,0,1,
                    0,1,0,1,0,0,0,0,0,0, 0,1,0,0};
  bit e_s3  [N] = '{0,0,0,0,1,0,0,0,0,1, 1,1,0,0,1,0,0,0,1,0,
                    1,0,1,0,1,0,0,0,0,0, 0,0,1,0};
  bit e_s2r1[N] = '{1,1,1,1,0,0,0,0,1,1, 1,0,0,1,0,0,0,1,0,1,
                    0,1,0,1,0,0,0,1,1,0, 0,1,0,0};
`endif

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    r_in  = 1'b1;
    for (int j = 0; j < N; j++) begin
      reset = v_rst[j];
      r_in  = v_in[j];
      @(posedge clk);
      #1;
      check_bit($sformatf("s2_cyc%0d", j),   w_out2,   e_s2[j]);
      check_bit($sformatf("s3_cyc%0d", j),   w_out3,   e_s3[j]);
      check_bit($sformatf("s2r1_cyc%0d", j), w_out2r1, e_s2r1[j]);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
